// File: rtl/weighted_pred_unit_pkg.sv
// Shared constants and types for the H.264 weighted sample prediction unit.
package weighted_pred_unit_pkg;

  localparam int unsigned WP_ACC_W = 19;
  localparam int unsigned WP_MUL_W = 17;
  localparam int unsigned WP_LANES = 4;

  localparam logic [1:0] PD_L0 = 2'b01;
  localparam logic [1:0] PD_L1 = 2'b10;
  localparam logic [1:0] PD_BI = 2'b11;

  localparam int CLIP_MIN = 0;
  localparam int CLIP_MAX = 255;

  typedef logic signed [WP_ACC_W-1:0] wp_acc_t;
  typedef logic signed [WP_MUL_W-1:0] wp_mul_t;

  typedef struct packed {
    logic [1:0] dir;
    logic       expl;
    logic [2:0] log_wd;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] o0;
    logic [7:0] o1;
  } wp_cfg_t;

  // The illegal direction 00 behaves as L0 only.
  function automatic logic [1:0] norm_dir(input logic [1:0] dir);
    return (dir == 2'b00) ? PD_L0 : dir;
  endfunction

endpackage

// File: rtl/wp_lane.sv
// One sample lane: multiply, round/shift, offset/clip, each stage registered on en.
module wp_lane
  import weighted_pred_unit_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                expl_a,
  input  logic [7:0]          w0_a,
  input  logic [7:0]          w1_a,
  input  logic [SAMPLE_W-1:0] x0,
  input  logic [SAMPLE_W-1:0] x1,
  input  logic                expl_b,
  input  logic                bi_b,
  input  logic                l1_b,
  input  logic [2:0]          log_wd_b,
  input  logic                expl_c,
  input  logic                bi_c,
  input  logic                l1_c,
  input  logic [7:0]          o0_c,
  input  logic [7:0]          o1_c,
  output logic [SAMPLE_W-1:0] y
);

  wp_mul_t p0_d, p1_d, p0_q, p1_q;
  wp_acc_t a0, a1, sel, r_d, r_q;
  wp_acc_t o0s, o1s, off, sum;
  logic [3:0] sh;
  logic [SAMPLE_W-1:0] y_d;

  // Stage 1: signed weight times unsigned sample; default mode passes samples through.
  always_comb begin
    p0_d = wp_mul_t'(x0);
    p1_d = wp_mul_t'(x1);
    if (expl_a) begin
      p0_d = wp_mul_t'($signed({1'b0, x0})) * wp_mul_t'($signed(w0_a));
      p1_d = wp_mul_t'($signed({1'b0, x1})) * wp_mul_t'($signed(w1_a));
    end
  end

  // Stage 2: rounding and arithmetic shift by the weight denominator.
  always_comb begin
    a0  = wp_acc_t'(p0_q);
    a1  = wp_acc_t'(p1_q);
    sel = l1_b ? a1 : a0;
    sh  = {1'b0, log_wd_b};
    r_d = sel;
    if (expl_b) begin
      if (bi_b)
        r_d = (a0 + a1 + (wp_acc_t'(1) <<< sh)) >>> (sh + 4'd1);
      else if (log_wd_b != 3'd0)
        r_d = (sel + (wp_acc_t'(1) <<< (sh - 4'd1))) >>> sh;
    end else if (bi_b) begin
      r_d = (a0 + a1 + wp_acc_t'(1)) >>> 1;
    end
  end

  // Stage 3: offset and clip to the sample range.
  always_comb begin
    o0s = wp_acc_t'($signed(o0_c));
    o1s = wp_acc_t'($signed(o1_c));
    off = '0;
    if (expl_c) begin
      if (bi_c)      off = (o0s + o1s + wp_acc_t'(1)) >>> 1;
      else if (l1_c) off = o1s;
      else           off = o0s;
    end
    sum = r_q + off;
    y_d = SAMPLE_W'(sum);
    if (sum < wp_acc_t'(CLIP_MIN))      y_d = SAMPLE_W'(CLIP_MIN);
    else if (sum > wp_acc_t'(CLIP_MAX)) y_d = SAMPLE_W'(CLIP_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_q <= '0;
      p1_q <= '0;
      r_q  <= '0;
      y    <= '0;
    end else if (en) begin
      p0_q <= p0_d;
      p1_q <= p1_d;
      r_q  <= r_d;
      y    <= y_d;
    end
  end

endmodule

// File: rtl/weighted_pred_unit.sv
// Weighted prediction top: handshake, row counter, per-block parameter snapshot, 4 lanes.
module weighted_pred_unit
  import weighted_pred_unit_pkg::*;
#(
  parameter int unsigned BLK_ROWS = 4,
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   pred_dir,
  input  logic                         explicit_wp,
  input  logic [2:0]                   logWD,
  input  logic [7:0]                   w0,
  input  logic [7:0]                   w1,
  input  logic [7:0]                   o0,
  input  logic [7:0]                   o1,
  input  logic [WP_LANES*SAMPLE_W-1:0] pred_l0,
  input  logic [WP_LANES*SAMPLE_W-1:0] pred_l1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WP_LANES*SAMPLE_W-1:0] pred_out,
  output logic                         blk_done,
  output logic [$clog2(BLK_ROWS)-1:0]  row_idx
);

  localparam int unsigned ROW_W = $clog2(BLK_ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BLK_ROWS - 1);

  logic en, accept;
  logic v1, v2;
  logic [ROW_W-1:0] in_row, row1, row2;
  wp_cfg_t cfg_in, snap, cfg_s0;
  logic [1:0] dir_s1, dir_s2;
  logic expl_s1, expl_s2;
  logic [2:0] lwd_s1;
  logic [7:0] o0_s1, o1_s1, o0_s2, o1_s2;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  assign cfg_in = '{dir: norm_dir(pred_dir), expl: explicit_wp, log_wd: logWD,
                    w0: w0, w1: w1, o0: o0, o1: o1};
  // Row 0 uses the live inputs (they are being snapshotted on the same edge).
  assign cfg_s0 = (in_row == '0) ? cfg_in : snap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_row <= '0;
      snap   <= '0;
    end else if (accept) begin
      in_row <= (in_row == LAST_ROW) ? '0 : in_row + ROW_W'(1);
      if (in_row == '0) snap <= cfg_in;
    end
  end

  // Control pipeline travelling alongside the lane datapaths.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      row1      <= '0;
      row2      <= '0;
      row_idx   <= '0;
      blk_done  <= 1'b0;
      dir_s1    <= '0;
      dir_s2    <= '0;
      expl_s1   <= 1'b0;
      expl_s2   <= 1'b0;
      lwd_s1    <= '0;
      o0_s1     <= '0;
      o1_s1     <= '0;
      o0_s2     <= '0;
      o1_s2     <= '0;
    end else if (en) begin
      v1        <= accept;
      v2        <= v1;
      out_valid <= v2;
      row1      <= in_row;
      row2      <= row1;
      row_idx   <= row2;
      blk_done  <= v2 && (row2 == LAST_ROW);
      dir_s1    <= cfg_s0.dir;
      dir_s2    <= dir_s1;
      expl_s1   <= cfg_s0.expl;
      expl_s2   <= expl_s1;
      lwd_s1    <= cfg_s0.log_wd;
      o0_s1     <= cfg_s0.o0;
      o1_s1     <= cfg_s0.o1;
      o0_s2     <= o0_s1;
      o1_s2     <= o1_s1;
    end
  end

  for (genvar l = 0; l < int'(WP_LANES); l++) begin : g_lane
    wp_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .expl_a   (cfg_s0.expl),
      .w0_a     (cfg_s0.w0),
      .w1_a     (cfg_s0.w1),
      .x0       (pred_l0[l*SAMPLE_W +: SAMPLE_W]),
      .x1       (pred_l1[l*SAMPLE_W +: SAMPLE_W]),
      .expl_b   (expl_s1),
      .bi_b     (dir_s1 == PD_BI),
      .l1_b     (dir_s1 == PD_L1),
      .log_wd_b (lwd_s1),
      .expl_c   (expl_s2),
      .bi_c     (dir_s2 == PD_BI),
      .l1_c     (dir_s2 == PD_L1),
      .o0_c     (o0_s2),
      .o1_c     (o1_s2),
      .y        (pred_out[l*SAMPLE_W +: SAMPLE_W])
    );
  end

endmodule

// File: doc/weighted_pred_unit.md
Name: weighted_pred_unit

Overview:
Downstream consumer of the prediction weight table outputs (logWD, w0/w1, o0/o1, weight flags). Applies H.264 weighted sample prediction to inter-predicted samples from the L0/L1 interpolators, one 4-sample row per beat, 4 rows per 4x4 block. Output feeds the reconstruction adder. The block is a 3-stage pipeline with valid/ready backpressure. Weights and mode are snapshotted per 4x4 block.

Parameters:
BLK_ROWS, 4, rows (beats) per 4x4 block; also the modulus of the row counter.
SAMPLE_W, 8, bits per sample.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  input row valid
in_ready  out  1  input accepted when in_valid & in_ready
pred_dir  in  2  01 = L0 only, 10 = L1 only, 11 = bi; 00 is illegal and treated as 01
explicit_wp  in  1  1 = explicit weighting (weight flag for the used list(s)); 0 = default
logWD  in  3  log2 weight denominator
w0, w1  in  8  signed weights
o0, o1  in  8  signed offsets
pred_l0  in  32  4 L0 samples, sample 0 in [7:0]
pred_l1  in  32  4 L1 samples
out_valid  out  1  output row valid
out_ready  in  1  downstream ready
pred_out  out  32  4 weighted samples
blk_done  out  1  high with the last row (row 3) of a block on the output
row_idx  out  2  row number of the current output row

Behaviour:
- Reset values: out_valid=0, pred_out=0, blk_done=0, row_idx=0, in_row counter=0, all stage valids=0, snapshot registers=0.
- Advance rule: en = !out_valid | out_ready. in_ready = en (combinational). All stages shift together when en=1 and hold when en=0. Bubbles are not collapsed.
- Latency: 3 cycles from accept to out_valid when out_ready stays high. Throughput is 1 row per cycle.
- Parameter snapshot: on an accepted beat with in_row==0, latch pred_dir, explicit_wp, logWD, w0, w1, o0, o1. Rows 1..3 use the latched values; input parameter changes mid-block are ignored.
- in_row increments on each accept and wraps 3→0. The value travels down the pipe as row_idx. blk_done = out_valid & row_idx==3.
- Stage 1, multiply: p0 = x0*w0 and p1 = x1*w1, with x unsigned 8 and w signed 8, giving 17-bit signed. Default mode skips the multiply and passes the raw samples.
- Stage 2, round/shift (arithmetic shifts, 19-bit signed):
  - Uni explicit, logWD≥1: (p + 2^(logWD-1)) >>> logWD.
  - Uni explicit, logWD=0: p.
  - Bi explicit: (p0 + p1 + 2^logWD) >>> (logWD+1).
  - Default uni: x.
  - Default bi: (x0 + x1 + 1) >> 1.
  - Uni L1 uses x1, w1, o1.
- Stage 3, offset and clip:
  - Uni explicit: + o (sign-extended).
  - Bi explicit: + ((o0 + o1 + 1) >>> 1).
  - Clip to [0,255]. Default modes add nothing.
- The 4 lanes are identical and independent.
- Reset mid-operation: all in-flight rows are discarded and the row counter returns to 0. The next accepted row is row 0.
- Simultaneous accept and output: both occur; no loss or duplication.

Decomposition:
- Shared package/define file holds:
  - pred_dir encodings PD_L0=2'b01, PD_L1=2'b10, PD_BI=2'b11.
  - Clip limits 0/255.
  - Intermediate width constant WP_ACC_W=19.
- One sub-module, wp_lane: a single-sample 3-stage datapath (multiply, round/shift, offset/clip) with enable. Instantiated 4 times.
- The top module holds handshake, row counter, parameter snapshot and blk_done/row_idx pipeline.

Test Plan:
- Reset, then explicit L0 with logWD=5, w0=32, o0=0 on a row of {10,20,30,40}: pred_out returns the same samples 3 cycles after accept. out_valid=0 and pred_out=0 during reset.
- Explicit L0 with logWD=0, w0=2, o0=-10, x=100 → 190. x=200 → 255 (high clip). w0=-1, o0=0, x=50 → 0 (low clip).
- Bi explicit with logWD=5, w0=w1=32, o0=4, o1=-1, x0=100, x1=50 → 77. Default bi with x0=10, x1=13 → 12. Default L1 passes x1 unchanged.
- Four back-to-back rows, with w0 changed from 32 to 64 at row 2: all four rows use w0=32. blk_done is high only with row_idx=3, and the next block starts at row_idx=0.
- out_ready held low for 5 cycles with the pipe full: in_ready=0, pred_out stable, no rows lost or duplicated. Order is preserved after release.
- reset_n asserted with 2 rows in flight: out_valid drops immediately. The first row after release reports row_idx=0 and loads a new snapshot.
